// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, frame-result kinds, matrix size.
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic {
    IDLE,
    HELD
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } res_kind_e;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; resets to zero.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/keypad_scan16.sv
// 4x4 hex keypad scanner: row strobe, frame-level debounce, one pulse per press,
// and a 16-bit shift register of the last four accepted codes.
module keypad_scan16
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  logic [3:0]    col_s;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [4:0]    ones_q, ones_d;
  logic [3:0]    acc_code_q, acc_code_d;
  res_kind_e     prev_kind_q, prev_kind_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  state_e        state_q, state_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [15:0]   data_q, data_d;

  logic [2:0]    row_ones;
  logic [1:0]    col_idx;
  logic [4:0]    frame_ones;
  logic [3:0]    frame_code;
  res_kind_e     frame_kind;
  logic          same_result;

  sync_2ff #(.W(COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col),
    .q     (col_s)
  );

  // Running frame result including the row currently being sampled.
  always_comb begin
    row_ones = '0;
    col_idx  = '0;
    for (int j = 0; j < COLS; j++) begin
      row_ones = row_ones + {2'b00, col_s[j]};
      if (col_s[j]) col_idx = 2'(j);
    end
    frame_ones = ones_q + {2'b00, row_ones};
    frame_code = (row_ones == 3'd1) ? {row_idx_q, col_idx} : acc_code_q;
    if (frame_ones == 5'd0)      frame_kind = NONE;
    else if (frame_ones == 5'd1) frame_kind = SINGLE;
    else                         frame_kind = MULTI;
    same_result = (frame_kind == prev_kind_q) &&
                  ((frame_kind != SINGLE) || (frame_code == prev_code_q));
  end

  always_comb begin
    dwell_d      = dwell_q + DW'(1);
    row_idx_d    = row_idx_q;
    ones_d       = ones_q;
    acc_code_d   = acc_code_q;
    prev_kind_d  = prev_kind_q;
    prev_code_d  = prev_code_q;
    stable_cnt_d = stable_cnt_q;
    state_d      = state_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    data_d       = data_q;

    if (dwell_q == DWELL_LAST) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      if (row_idx_q == 2'(ROWS - 1)) begin
        ones_d     = '0;
        acc_code_d = '0;
        if (same_result) begin
          if (stable_cnt_q != STABLE_MAX) stable_cnt_d = stable_cnt_q + SW'(1);
        end else begin
          stable_cnt_d = SW'(1);
          prev_kind_d  = frame_kind;
          prev_code_d  = frame_code;
        end
        if (stable_cnt_d == STABLE_MAX) begin
          case (state_q)
            IDLE: if (frame_kind == SINGLE) begin
              state_d     = HELD;
              key_valid_d = 1'b1;
              key_code_d  = frame_code;
              data_d      = {data_q[11:0], frame_code};
            end
            HELD: if (frame_kind == NONE) state_d = IDLE;
            default: state_d = IDLE;
          endcase
        end
      end else begin
        ones_d     = frame_ones;
        acc_code_d = frame_code;
      end
    end

    // Clear wins over a same-cycle shift but leaves the pulse and code alone.
    if (clr) data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q      <= '0;
      row_idx_q    <= '0;
      ones_q       <= '0;
      acc_code_q   <= '0;
      prev_kind_q  <= NONE;
      prev_code_q  <= '0;
      stable_cnt_q <= '0;
      state_q      <= IDLE;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      data_q       <= '0;
    end else begin
      dwell_q      <= dwell_d;
      row_idx_q    <= row_idx_d;
      ones_q       <= ones_d;
      acc_code_q   <= acc_code_d;
      prev_kind_q  <= prev_kind_d;
      prev_code_q  <= prev_code_d;
      stable_cnt_q <= stable_cnt_d;
      state_q      <= state_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      data_q       <= data_d;
    end
  end

  assign row       = 4'b0001 << row_idx_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign data      = data_q;
endmodule

// File: tb/tb_keypad_scan16.sv
// Bench for keypad_scan16 with SCAN_DIV=4, DEBOUNCE=2: keypad matrix model plus
// a frame-level reference model of debounce and key acceptance.
module tb_keypad_scan16;
  localparam int SD  = 4;
  localparam int DB  = 2;
  localparam int FRM = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clr = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  // Reference state: previous frame result, stable count, held flag, outputs.
  int          m_prev_kind, m_prev_code, m_cnt;
  bit          m_held;
  logic [3:0]  m_code;
  logic [15:0] m_data;

  keypad_scan16 #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .data      (data)
  );

  always #5 clk = ~clk;

  // Key with code c sits at row c/4, column c%4; pressing it shorts row to column.
  always_comb begin
    col = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keys[i*4+j] && row[i]) col[j] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_kind = 0;
    m_prev_code = 0;
    m_cnt       = 0;
    m_held      = 1'b0;
    m_code      = '0;
    m_data      = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_row", {28'd0, row}, 32'h1);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_data", {16'd0, data}, 32'h0);
    keys = '0;
    clr  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds the key mask for one full frame; optionally raises clr on the frame's last cycle.
  task automatic run_frame(input logic [15:0] mask, input bit clr_end);
    int pc, kind, code;
    bit pulse;
    keys = mask;
    pc = $countones(mask);
    kind = (pc == 0) ? 0 : (pc == 1) ? 1 : 2;
    code = 0;
    for (int b = 0; b < 16; b++) if (mask[b]) code = b;
    if (kind == m_prev_kind && (kind != 1 || code == m_prev_code)) begin
      if (m_cnt < DB) m_cnt++;
    end else begin
      m_cnt = 1;
      m_prev_kind = kind;
      m_prev_code = code;
    end
    pulse = 1'b0;
    if (m_cnt == DB) begin
      if (!m_held && kind == 1) begin
        pulse  = 1'b1;
        m_held = 1'b1;
        m_code = 4'(code);
        m_data = {m_data[11:0], 4'(code)};
      end else if (m_held && kind == 0) begin
        m_held = 1'b0;
      end
    end
    if (clr_end) m_data = '0;

    for (int k = 1; k <= FRM; k++) begin
      if (k == FRM) clr = clr_end;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("row", {28'd0, row}, 32'(4'b0001 << ((k / SD) % 4)));
      chk("valid", {31'd0, key_valid}, (k == FRM) ? {31'd0, pulse} : 32'h0);
    end
    chk("code", {28'd0, key_code}, {28'd0, m_code});
    chk("data", {16'd0, data}, {16'd0, m_data});
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    for (int f = 0; f < n; f++) run_frame(mask, 1'b0);
  endtask

  initial begin
    model_reset();
    #3;
    do_reset();

    // Asynchronous reset in the middle of a frame.
    keys = 16'h0040;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
    end
    #2;
    do_reset();

    // Key (1,2) held for four frames, then released.
    run_frames(16'h0040, 4);
    chk("k6_code", {28'd0, key_code}, 32'h6);
    chk("k6_data", {16'd0, data}, 32'h0006);
    run_frames(16'h0000, 3);

    // Press/release sequence 1, 2, 3, 4, A.
    for (int n = 1; n <= 4; n++) begin
      run_frames(16'(1 << n), 3);
      run_frames(16'h0000, 3);
    end
    chk("seq_1234", {16'd0, data}, 32'h1234);
    run_frames(16'h0400, 3);
    run_frames(16'h0000, 3);
    chk("seq_234A", {16'd0, data}, 32'h234A);

    // Key 0 bouncing each frame, then held without auto-repeat.
    for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0);
    run_frames(16'h0001, 3);
    chk("bounce_code", {28'd0, key_code}, 32'h0);
    chk("bounce_data", {16'd0, data}, 32'h34A0);
    run_frames(16'h0001, 10);
    run_frames(16'h0000, 3);

    // Keys 5 and 9 together, then 9 released.
    run_frames(16'h0220, 4);
    chk("multi_data", {16'd0, data}, 32'h34A0);
    run_frames(16'h0020, 3);
    chk("multi_code", {28'd0, key_code}, 32'h5);
    run_frames(16'h0000, 3);

    // Clear coinciding with acceptance of key F.
    run_frame(16'h8000, 1'b0);
    run_frame(16'h8000, 1'b1);
    chk("clr_valid", {31'd0, key_valid}, 32'h1);
    chk("clr_code", {28'd0, key_code}, 32'hF);
    chk("clr_data", {16'd0, data}, 32'h0);
    run_frames(16'h0000, 3);

    // Reset after one stable frame of a press.
    run_frame(16'h0100, 1'b0);
    do_reset();
    run_frame(16'h0100, 1'b0);
    run_frames(16'h0000, 2);
    chk("rstpress_data", {16'd0, data}, 32'h0);

    // Randomized presses, chords, bounces and releases.
    for (int r = 0; r < 40; r++) begin
      int mode, a, b, len;
      logic [15:0] m;
      mode = $urandom_range(3);
      a = $urandom_range(15);
      b = (a + 1 + $urandom_range(14)) % 16;
      len = 1 + $urandom_range(3);
      case (mode)
        0: m = 16'h0000;
        1, 2: m = 16'(1 << a);
        default: m = 16'(1 << a) | 16'(1 << b);
      endcase
      for (int f = 0; f < len; f++) run_frame(m, ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
